uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10416, clock cycles per serial bit; legal range 4..65535.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 rx_serial  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 rx_rd  input  1  consumer acknowledge; clears held byte when rx_valid=1.
REQ-006 rx_dout  output  8  last received byte, held stable while rx_valid=1.
REQ-007 rx_valid  output  1  level; byte available in rx_dout.
REQ-008 rx_active  output  1  high while a frame is in progress (states START, DATA, STOP).
REQ-009 rx_frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-010 rx_overrun  output  1  sticky; a byte completed while rx_valid=1 and no rx_rd.

Function
REQ-011 rx_serial SHALL pass through a 2-flop synchronizer (flops reset to 1); all logic uses the synchronized value rx_s.
REQ-012 FSM states: IDLE, START, DATA, STOP, WAIT_HIGH; 16-bit clk_count, 3-bit bit_index.
REQ-013 IDLE: clk_count=0, bit_index=0; rx_s=0 -> START.
REQ-014 START: count to (CLKS_PER_BIT-1)/2 (integer); at that count rx_s=0 -> DATA, clk_count=0; rx_s=1 -> IDLE (glitch rejected, no flag).
REQ-015 DATA: count to CLKS_PER_BIT-1; at that count sample rx_s into shift register bit bit_index, clk_count=0; after bit_index 7 -> STOP, else bit_index+1.
REQ-016 STOP: count to CLKS_PER_BIT-1; at that count rx_s=1 -> deliver byte, IDLE; rx_s=0 -> rx_frame_err pulse, byte discarded, WAIT_HIGH.
REQ-017 WAIT_HIGH: remain until rx_s=1, then IDLE; no start detection while in WAIT_HIGH (break handling).
REQ-018 Deliver with rx_valid=0: rx_dout<=byte, rx_valid<=1 on next clock edge.
REQ-019 Deliver with rx_valid=1 and rx_rd=0: byte discarded, rx_dout unchanged, rx_overrun<=1.
REQ-020 Deliver and rx_rd=1 same cycle: rx_dout<=new byte, rx_valid stays 1, no overrun.
REQ-021 rx_rd=1 with no deliver: rx_valid<=0, rx_overrun<=0; rx_rd with rx_valid=0 has no effect on rx_valid/rx_dout but clears rx_overrun.
REQ-022 Latency: rx_valid rises (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + 3..5 cycles after rx_serial falling edge.
REQ-023 Back-to-back frames: start bit immediately following a valid stop sample SHALL be detected (IDLE lasts one cycle minimum).
REQ-024 Counters SHALL never wrap; clk_count compares use full 16-bit width.

Reset
REQ-025 rst_n=0 at a clock edge: FSM->IDLE, clk_count=0, bit_index=0, shift register=0, synchronizer flops=1.
REQ-026 Output reset values: rx_dout=8'h00, rx_valid=0, rx_active=0, rx_frame_err=0, rx_overrun=0.
REQ-027 Reset mid-frame SHALL abandon the frame; no rx_valid or rx_frame_err from the abandoned frame.
REQ-028 After release, a frame starting no earlier than 3 cycles later SHALL be received correctly.

Verification (CLKS_PER_BIT=16)
REQ-029 Send 8'hA5 with valid stop -> rx_valid rises 154..156 cycles after start edge, rx_dout=8'hA5, rx_frame_err never asserted.
REQ-030 Low pulse of 4 cycles on idle line -> rx_active high briefly then low, no rx_valid, no rx_frame_err.
REQ-031 Send 8'h3C with stop bit low, line held low 40 more cycles -> one rx_frame_err pulse, rx_valid stays 0, next frame 8'h81 after line high received correctly.
REQ-032 Send 8'h11 then 8'h22 back-to-back without rx_rd -> rx_dout=8'h11, rx_overrun=1; rx_rd -> rx_valid=0, rx_overrun=0.
REQ-033 rx_rd asserted in the exact cycle second byte 8'h22 delivers -> rx_dout=8'h22, rx_valid=1, rx_overrun=0.
REQ-034 rst_n=0 for 2 cycles during bit 4 of a frame -> all outputs at reset values, no delivery; subsequent 8'h5A received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 serial receiver with a one-byte holding register.
//
// Ports
//   clk           : single clock, all state updates on the rising edge
//   rst_n         : synchronous, active-low reset
//   rx_serial     : asynchronous serial line, idle high, LSB first
//   rx_rd         : consumer acknowledge for the held byte
//   rx_dout[7:0]  : last received byte, stable while rx_valid is high
//   rx_valid      : level, a byte is waiting in rx_dout
//   rx_active     : high while a frame is being received (START/DATA/STOP)
//   rx_frame_err  : one-cycle pulse when the stop bit is sampled low
//   rx_overrun    : sticky, a byte completed while the previous one was unread
//   dbg_state[2:0]: current receiver state, for observation only
//
// Handshake: rx_valid/rx_rd form a level/acknowledge pair. rx_valid stays
// high with rx_dout frozen until a cycle in which rx_rd=1 is sampled; that
// cycle consumes the byte. A new byte arriving while rx_valid=1 and no rx_rd
// is dropped and raises rx_overrun; rx_rd in the same cycle as a new byte
// lets the new byte replace the old one without an overrun.
module uart_rx #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_serial,
    input  logic       rx_rd,
    output logic [7:0] rx_dout,
    output logic       rx_valid,
    output logic       rx_active,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    // Mid-bit point of the start bit, and the last count of a full bit.
    localparam logic [15:0] HALF_COUNT = 16'((CLKS_PER_BIT - 1) / 2);
    localparam logic [15:0] LAST_COUNT = 16'(CLKS_PER_BIT - 1);

    logic        rx_meta;
    logic        rx_s;
    state_t      state,     state_nx;
    logic [15:0] clk_count, clk_count_nx;
    logic [2:0]  bit_index, bit_index_nx;
    logic [7:0]  shift_reg, shift_reg_nx;
    logic [7:0]  dout_nx;
    logic        valid_nx;
    logic        overrun_nx;
    logic        frame_err_nx;
    logic        deliver;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta      <= 1'b1;
            rx_s         <= 1'b1;
            state        <= IDLE;
            clk_count    <= 16'd0;
            bit_index    <= 3'd0;
            shift_reg    <= 8'h00;
            rx_dout      <= 8'h00;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            rx_meta      <= rx_serial;
            rx_s         <= rx_meta;
            state        <= state_nx;
            clk_count    <= clk_count_nx;
            bit_index    <= bit_index_nx;
            shift_reg    <= shift_reg_nx;
            rx_dout      <= dout_nx;
            rx_valid     <= valid_nx;
            rx_frame_err <= frame_err_nx;
            rx_overrun   <= overrun_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        clk_count_nx = clk_count;
        bit_index_nx = bit_index;
        shift_reg_nx = shift_reg;
        frame_err_nx = 1'b0;
        deliver      = 1'b0;

        case (state)
            IDLE: begin
                clk_count_nx = 16'd0;
                bit_index_nx = 3'd0;
                if (!rx_s) state_nx = START;
            end
            START: begin
                if (clk_count == HALF_COUNT) begin
                    clk_count_nx = 16'd0;
                    // Line back high at mid start bit: treat as a glitch.
                    state_nx     = rx_s ? IDLE : DATA;
                end else begin
                    clk_count_nx = clk_count + 16'd1;
                end
            end
            DATA: begin
                if (clk_count == LAST_COUNT) begin
                    clk_count_nx            = 16'd0;
                    shift_reg_nx[bit_index] = rx_s;
                    if (bit_index == 3'd7) begin
                        bit_index_nx = 3'd0;
                        state_nx     = STOP;
                    end else begin
                        bit_index_nx = bit_index + 3'd1;
                    end
                end else begin
                    clk_count_nx = clk_count + 16'd1;
                end
            end
            STOP: begin
                if (clk_count == LAST_COUNT) begin
                    clk_count_nx = 16'd0;
                    if (rx_s) begin
                        deliver  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        frame_err_nx = 1'b1;
                        state_nx     = WAIT_HIGH;
                    end
                end else begin
                    clk_count_nx = clk_count + 16'd1;
                end
            end
            WAIT_HIGH: begin
                // A held-low line (break) must return high before the next
                // start bit can be recognised.
                clk_count_nx = 16'd0;
                if (rx_s) state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        dout_nx    = rx_dout;
        valid_nx   = rx_valid;
        overrun_nx = rx_overrun;
        if (deliver) begin
            if (!rx_valid || rx_rd) begin
                dout_nx  = shift_reg;
                valid_nx = 1'b1;
                if (rx_rd) overrun_nx = 1'b0;
            end else begin
                overrun_nx = 1'b1;
            end
        end else if (rx_rd) begin
            valid_nx   = 1'b0;
            overrun_nx = 1'b0;
        end
    end

    assign rx_active = (state == START) || (state == DATA) || (state == STOP);
    assign dbg_state = state;

endmodule
